regfile_mp_sb: RTL
==================

// Module: regfile_mp_sb
// PURPOSE
//  Parametrised multi-port register file for the pipelined CPU: NUM_RD combinational read ports,
//  two write ports (port 1 = later pipeline stage, higher priority), optional hardwired-zero entry 0,
//  optional write-to-read bypass, and a per-register pending-write scoreboard with a pending counter.
//  Sits between ID (reads, issue/scoreboard set) and WB/late-WB (writes), and feeds hazard detection.
// PARAMETERS
//  DATA_W    32  data width of each register
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W entries
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  1   1: entry 0 reads 0, ignores writes and sb_set; 0: entry 0 is ordinary
//  BYPASS    1   1: same-cycle write data forwarded to matching read ports; 0: reads see stored value only
// PORTS
//  clk          in   1               rising-edge clock
//  reset        in   1               asynchronous, active-low; 0 clears all state
//  rd_addr      in   NUM_RD*ADDR_W   read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_data      out  NUM_RD*DATA_W   read data, port k at [k*DATA_W +: DATA_W]
//  rd_pending   out  NUM_RD          1: register at rd_addr[k] has an outstanding write
//  we0/wa0/wd0  in   1/ADDR_W/DATA_W write port 0 enable/address/data
//  we1/wa1/wd1  in   1/ADDR_W/DATA_W write port 1 enable/address/data (priority over port 0)
//  sb_set       in   1               mark register sb_addr as pending (issue of a producer)
//  sb_addr      in   ADDR_W          scoreboard set address
//  pend_cnt     out  ADDR_W+1        number of pending bits currently set
// BEHAVIOUR
//  Reset (reset==0, async): all DEPTH registers <= 0, all pending bits <= 0, pend_cnt <= 0.
//   While reset is low, rd_data = 0 and rd_pending = 0 on every port, and bypass is inactive.
//  Writes: on posedge clk, weN writes wdN to entry waN. If we0 && we1 && wa0==wa1, only wd1 is stored.
//   When ZERO_REG=1, writes to address 0 are dropped; entry 0 always reads 0.
//  Reads: combinational, zero latency. Value for port k, in priority order:
//   (1) ZERO_REG && addr==0 -> 0; (2) BYPASS && we1 && wa1==addr -> wd1;
//   (3) BYPASS && we0 && wa0==addr -> wd0; (4) stored entry.
//  Scoreboard: one pending bit per entry, registered.
//   Any accepted write (weN, address not dropped) clears that entry's bit at the clock edge.
//   sb_set sets bit sb_addr at the clock edge; set wins over a same-cycle clear of the same entry
//   (a new producer is now in flight). sb_set to entry 0 is ignored when ZERO_REG=1.
//   sb_set on an already-pending entry leaves it pending (no double count).
//  rd_pending[k]: stored pending bit of rd_addr[k]. With BYPASS=1 it is forced to 0 when that entry is
//   written this cycle (data is forwarded). Always 0 for address 0 when ZERO_REG=1.
//  pend_cnt: registered; after every edge it equals the popcount of the pending bits.
//   Range 0..DEPTH, so pend_cnt never wraps. Incremental update is permitted only if it matches this
//   every cycle, including set+clear of different entries in the same cycle, two clears in one cycle,
//   and set+clear of the same entry (net 0 if the bit was already 1, +1 if it was 0).
//  Reset asserted mid-operation: state clears immediately. Writes and sets presented on the edge where
//   reset is released are ignored; the first accepted operation is on the following edge.
// TESTING
//  T1 reset low, then release; read all 32 addrs on both ports -> rd_data=0, rd_pending=0, pend_cnt=0.
//  T2 we0 wa0=5 wd0=0xDEADBEEF, rd_addr[0]=5 same cycle -> rd_data[0]=0xDEADBEEF (bypass);
//     next cycle with we0=0 -> still 0xDEADBEEF (stored).
//  T3 we0 wa0=7 wd0=0x11, we1 wa1=7 wd1=0x22 same cycle -> reg7=0x22; bypass read of 7 returns 0x22.
//  T4 sb_set sb_addr=9 -> rd_pending=1 for addr 9, pend_cnt=1; sb_set 9 again -> pend_cnt stays 1;
//     we1 wa1=9 -> rd_pending forced 0 in that cycle, pend_cnt=0 after the edge.
//  T5 ZERO_REG=1: we0 wa0=0 wd0=0xFFFFFFFF and sb_set sb_addr=0 -> reads of 0 return 0,
//     rd_pending=0, pend_cnt unchanged.
//  T6 sb_set 3 and 4, then same cycle sb_set 3 + we0 wa0=3 + we1 wa1=4 -> bit3=1, bit4=0, pend_cnt=1;
//     then pulse reset low mid-run -> pend_cnt=0 and all regs=0 immediately.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with two prioritised write ports, bypass and pending-write scoreboard
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic [ADDR_W:0]          pend_cnt
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend, pend_nx;
  logic [ADDR_W:0]   cnt_nx;
  logic              run, a0, a1, s;
  // run holds off the first edge after reset release so ops presented there are dropped
  assign a0 = run && we0 && !(ZERO_REG != 0 && wa0 == '0);
  assign a1 = run && we1 && !(ZERO_REG != 0 && wa1 == '0);
  assign s  = run && sb_set && !(ZERO_REG != 0 && sb_addr == '0);
  always_comb begin
    pend_nx = pend;
    if (a0) pend_nx[wa0] = 1'b0;
    if (a1) pend_nx[wa1] = 1'b0;
    if (s) pend_nx[sb_addr] = 1'b1;
    cnt_nx = (ADDR_W+1)'($countones(pend_nx));
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend     <= '0;
      pend_cnt <= '0;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (a0) mem[wa0] <= wd0;
      if (a1) mem[wa1] <= wd1;
      pend     <= pend_nx;
      pend_cnt <= cnt_nx;
    end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              zero, b0, b1;
    assign addr = rd_addr[k*ADDR_W +: ADDR_W];
    assign zero = ZERO_REG != 0 && addr == '0;
    assign b1   = BYPASS != 0 && a1 && wa1 == addr;
    assign b0   = BYPASS != 0 && a0 && wa0 == addr;
    assign rd_data[k*DATA_W +: DATA_W] = (!reset || zero) ? '0 : b1 ? wd1 : b0 ? wd0 : mem[addr];
    assign rd_pending[k] = reset && !zero && !b1 && !b0 && pend[addr];
  end
endmodule
